// File: rtl/hex_digit_counter.sv
// Hex digit source for the 7-segment path: a rate divider paces a 4-bit
// modulo-16 up/down counter with parallel load; tick/wrap flag each step.
module hex_digit_counter #(
  parameter int CLK_FREQ = 50000000,
  parameter int DIV_W    = 32
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       up,
  input  logic [1:0] rate_sel,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic [3:0] count,
  output logic       tick,
  output logic       wrap
);

  localparam logic [DIV_W-1:0] DIV_ZERO = {DIV_W{1'b0}};
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  logic [3:0]       count_q, count_d;
  logic             tick_q, tick_d;
  logic             wrap_q, wrap_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [1:0]       rate_q, rate_d;

  // Divider reload is period-1, so a zero reload steps on every enabled edge.
  function automatic logic [DIV_W-1:0] reload_val(input logic [1:0] sel);
    logic [DIV_W-1:0] r;
    case (sel)
      2'b00:   r = DIV_ZERO;
      2'b01:   r = DIV_W'(CLK_FREQ - 1);
      2'b10:   r = DIV_W'(2 * CLK_FREQ - 1);
      2'b11:   r = DIV_W'(4 * CLK_FREQ - 1);
      default: r = DIV_ZERO;
    endcase
    return r;
  endfunction

  // Next-state: load beats a rate change, which beats a step; a pending step is dropped by either.
  always_comb begin
    count_d   = count_q;
    div_cnt_d = div_cnt_q;
    rate_d    = rate_q;
    tick_d    = 1'b0;
    wrap_d    = 1'b0;
    if (load) begin
      count_d   = load_val;
      div_cnt_d = reload_val(rate_sel);
      rate_d    = rate_sel;
    end else if (rate_sel != rate_q) begin
      div_cnt_d = reload_val(rate_sel);
      rate_d    = rate_sel;
    end else if (enable) begin
      if (div_cnt_q == DIV_ZERO) begin
        count_d   = up ? (count_q + 4'h1) : (count_q - 4'h1);
        wrap_d    = up ? (count_q == 4'hF) : (count_q == 4'h0);
        tick_d    = 1'b1;
        div_cnt_d = reload_val(rate_q);
      end else begin
        div_cnt_d = div_cnt_q - DIV_ONE;
      end
    end else begin
      div_cnt_d = div_cnt_q;
    end
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q   <= 4'h0;
      tick_q    <= 1'b0;
      wrap_q    <= 1'b0;
      div_cnt_q <= reload_val(rate_sel);
      rate_q    <= rate_sel;
    end else begin
      count_q   <= count_d;
      tick_q    <= tick_d;
      wrap_q    <= wrap_d;
      div_cnt_q <= div_cnt_d;
      rate_q    <= rate_d;
    end
  end

  assign count = count_q;
  assign tick  = tick_q;
  assign wrap  = wrap_q;

endmodule

// File: tb/tb_hex_digit_counter.sv
// Directed bench for hex_digit_counter with CLK_FREQ=4; each task checks its own scenario.
module tb_hex_digit_counter;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic       up = 1'b1;
  logic [1:0] rate_sel = 2'b00;
  logic       load = 1'b0;
  logic [3:0] load_val = 4'h0;
  logic [3:0] count;
  logic       tick;
  logic       wrap;

  int n_checks = 0;
  int n_fail   = 0;

  hex_digit_counter #(.CLK_FREQ(4), .DIV_W(32)) dut (
    .clock(clock), .reset(reset), .enable(enable), .up(up), .rate_sel(rate_sel),
    .load(load), .load_val(load_val), .count(count), .tick(tick), .wrap(wrap)
  );

  always #5 clock = ~clock;

  // One rising edge, then settle so outputs are sampled away from the edge.
  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset(input logic [1:0] rs);
    reset = 1'b1; enable = 1'b0; load = 1'b0; rate_sel = rs;
    cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] exp_c;
    logic       exp_t;
    up = 1'b1;
    do_reset(2'b01);
    n_checks++; if (count !== 4'h0) begin $display("FAIL reset_count got %h expected 0", count); n_fail++; end
    n_checks++; if (tick !== 1'b0) begin $display("FAIL reset_tick got %b expected 0", tick); n_fail++; end
    n_checks++; if (wrap !== 1'b0) begin $display("FAIL reset_wrap got %b expected 0", wrap); n_fail++; end
    enable = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      cycle();
      exp_c = 4'(e / 4);
      exp_t = ((e % 4) == 0);
      n_checks++;
      if (count !== exp_c) begin $display("FAIL reset_seq_count edge %0d got %h expected %h", e, count, exp_c); n_fail++; end
      n_checks++;
      if (tick !== exp_t) begin $display("FAIL reset_seq_tick edge %0d got %b expected %b", e, tick, exp_t); n_fail++; end
    end
  endtask

  task automatic test_fast_wrap();
    logic [3:0] exp_c;
    logic       exp_w;
    up = 1'b1;
    do_reset(2'b00);
    enable = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      cycle();
      exp_c = 4'(k % 16);
      exp_w = (k == 16);
      n_checks++;
      if (count !== exp_c) begin $display("FAIL wrap_count edge %0d got %h expected %h", k, count, exp_c); n_fail++; end
      n_checks++;
      if (tick !== 1'b1) begin $display("FAIL wrap_tick edge %0d got %b expected 1", k, tick); n_fail++; end
      n_checks++;
      if (wrap !== exp_w) begin $display("FAIL wrap_flag edge %0d got %b expected %b", k, wrap, exp_w); n_fail++; end
    end
  endtask

  task automatic test_down_load();
    logic [3:0] exp_seq [4];
    exp_seq = '{4'h1, 4'h0, 4'hF, 4'hE};
    enable = 1'b0; up = 1'b0; rate_sel = 2'b00; load = 1'b1; load_val = 4'h2;
    cycle();
    load = 1'b0;
    n_checks++; if (count !== 4'h2) begin $display("FAIL load_count got %h expected 2", count); n_fail++; end
    n_checks++; if (tick !== 1'b0) begin $display("FAIL load_tick got %b expected 0", tick); n_fail++; end
    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      n_checks++;
      if (count !== exp_seq[i]) begin $display("FAIL down_count step %0d got %h expected %h", i, count, exp_seq[i]); n_fail++; end
      n_checks++;
      if (wrap !== (i == 2)) begin $display("FAIL down_wrap step %0d got %b expected %b", i, wrap, (i == 2)); n_fail++; end
      n_checks++;
      if (tick !== 1'b1) begin $display("FAIL down_tick step %0d got %b expected 1", i, tick); n_fail++; end
    end
  endtask

  task automatic test_pause();
    up = 1'b1;
    do_reset(2'b10);
    for (int e = 1; e <= 13; e++) begin
      enable = !(e >= 4 && e <= 8);
      cycle();
      n_checks++;
      if (tick !== (e == 13)) begin $display("FAIL pause_tick edge %0d got %b expected %b", e, tick, (e == 13)); n_fail++; end
      n_checks++;
      if (count !== ((e == 13) ? 4'h1 : 4'h0)) begin $display("FAIL pause_count edge %0d got %h", e, count); n_fail++; end
    end
  endtask

  task automatic test_rate_change();
    up = 1'b1;
    do_reset(2'b11);
    enable = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      cycle();
      n_checks++;
      if (tick !== 1'b0) begin $display("FAIL rate_pre_tick edge %0d got %b expected 0", e, tick); n_fail++; end
    end
    rate_sel = 2'b01;
    cycle();
    n_checks++; if (tick !== 1'b0) begin $display("FAIL rate_change_tick got %b expected 0", tick); n_fail++; end
    n_checks++; if (count !== 4'h0) begin $display("FAIL rate_change_count got %h expected 0", count); n_fail++; end
    for (int i = 1; i <= 4; i++) begin
      cycle();
      n_checks++;
      if (tick !== (i == 4)) begin $display("FAIL rate_post_tick edge %0d got %b expected %b", i, tick, (i == 4)); n_fail++; end
      n_checks++;
      if (count !== ((i == 4) ? 4'h1 : 4'h0)) begin $display("FAIL rate_post_count edge %0d got %h", i, count); n_fail++; end
    end
  endtask

  task automatic test_conflicts();
    up = 1'b1;
    do_reset(2'b01);
    enable = 1'b1;
    repeat (3) cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    n_checks++; if (count !== 4'h0) begin $display("FAIL conflict_reset_count got %h expected 0", count); n_fail++; end
    n_checks++; if (tick !== 1'b0) begin $display("FAIL conflict_reset_tick got %b expected 0", tick); n_fail++; end
    repeat (3) cycle();
    load = 1'b1; load_val = 4'hA;
    cycle();
    load = 1'b0;
    n_checks++; if (count !== 4'hA) begin $display("FAIL conflict_load_count got %h expected a", count); n_fail++; end
    n_checks++; if (tick !== 1'b0) begin $display("FAIL conflict_load_tick got %b expected 0", tick); n_fail++; end
    n_checks++; if (wrap !== 1'b0) begin $display("FAIL conflict_load_wrap got %b expected 0", wrap); n_fail++; end
    for (int i = 1; i <= 4; i++) begin
      cycle();
      n_checks++;
      if (tick !== (i == 4)) begin $display("FAIL post_load_tick edge %0d got %b expected %b", i, tick, (i == 4)); n_fail++; end
      n_checks++;
      if (count !== ((i == 4) ? 4'hB : 4'hA)) begin $display("FAIL post_load_count edge %0d got %h", i, count); n_fail++; end
    end
  endtask

  initial begin
    test_reset();
    test_fast_wrap();
    test_down_load();
    test_pause();
    test_rate_change();
    test_conflicts();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
